// File: rtl/e100_bus_fabric.sv
// e100_bus_fabric: one-hot AND-OR bus mux with keeper, slow-source settle stall and sticky contention flag
module e100_bus_fabric #(
   parameter int                 WIDTH     = 32,
   parameter int                 NUM_SRC   = 16,
   parameter logic [NUM_SRC-1:0] SLOW_MASK = 16'h000C,
   parameter int                 SLOW_LAT  = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clock_valid,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   input  logic [NUM_SRC-1:0]       drive,
   output logic [WIDTH-1:0]         bus,
   output logic                     bus_valid,
   output logic                     stall,
   output logic                     contention,
   output logic [NUM_SRC-1:0]       contention_src
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   localparam logic [7:0] RELOAD = (SLOW_LAT > 1) ? 8'(SLOW_LAT - 2) : 8'd0;
   state_t             state, state_n;
   logic [7:0]         count, count_n;
   logic [NUM_SRC-1:0] drive_q;
   logic [WIDTH-1:0]   keeper, sel;
   logic               seen, multi, slow_sel, same, done_hold, fast_ok;
   // classify the drive vector and AND-OR the enabled sources together
   always_comb begin
      seen  = 1'b0;
      multi = 1'b0;
      sel   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         multi = multi | (seen & drive[i]);
         seen  = seen | drive[i];
         sel   = sel | (src_data[i*WIDTH +: WIDTH] & {WIDTH{drive[i]}});
      end
   end
   assign slow_sel  = seen && !multi && |(drive & SLOW_MASK);
   assign fast_ok   = seen && !multi && !slow_sel;
   assign same      = drive == drive_q;
   assign done_hold = state == S_DONE && same && !multi;
   // state register: advances only on qualified edges
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         count   <= '0;
         drive_q <= '0;
      end else if (clock_valid) begin
         state   <= state_n;
         count   <= count_n;
         drive_q <= drive;
      end
   end
   // next state: count down an unchanged slow drive, otherwise re-evaluate as from idle
   always_comb begin
      state_n = state;
      count_n = count;
      if (state == S_WAIT && same && !multi) begin
         state_n = (count == 8'd0) ? S_DONE : S_WAIT;
         count_n = (count == 8'd0) ? count : count - 8'd1;
      end else if (!done_hold) begin
         state_n = slow_sel ? ((SLOW_LAT == 1) ? S_DONE : S_WAIT) : S_IDLE;
         count_n = RELOAD;
      end
   end
   // outputs: forced quiet while reset is asserted, keeper shown whenever no settled value
   always_comb begin
      bus_valid = reset && (fast_ok || (slow_sel && done_hold));
      stall     = reset && (state == S_WAIT || (slow_sel && !done_hold));
      bus       = !reset ? '0 : bus_valid ? sel : keeper;
   end
   // keeper holds the last settled value; contention records only the first offending drive
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         keeper         <= '0;
         contention     <= 1'b0;
         contention_src <= '0;
      end else if (clock_valid) begin
         if (bus_valid) keeper <= bus;
         if (multi) begin
            contention <= 1'b1;
            if (!contention) contention_src <= drive;
         end
      end
   end
endmodule

// File: tb/tb_e100_bus_fabric.sv
// tb_e100_bus_fabric: directed checks of the bus fabric mux, keeper, slow stall, contention and reset
module tb_e100_bus_fabric;
   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         clock_valid = 1'b1;
   logic [511:0] src_data = '0;
   logic [15:0]  drive = '0;
   logic [31:0]  bus;
   logic         bus_valid, stall, contention;
   logic [15:0]  contention_src;
   int           n_cmp = 0;
   int           n_bad = 0;

   e100_bus_fabric dut (
      .clock(clock), .reset(reset), .clock_valid(clock_valid), .src_data(src_data),
      .drive(drive), .bus(bus), .bus_valid(bus_valid), .stall(stall),
      .contention(contention), .contention_src(contention_src)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(negedge clock);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (bus !== 32'h0) begin n_bad++; $display("FAIL rst_bus: got %h want %h", bus, 32'h0); end
      n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus_valid); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
      n_cmp++; if (contention !== 1'b0) begin n_bad++; $display("FAIL rst_cont: got %b want 0", contention); end
      n_cmp++; if (contention_src !== 16'h0) begin n_bad++; $display("FAIL rst_csrc: got %h want 0000", contention_src); end
      @(negedge clock);
      reset = 1'b1;
      cyc();
   endtask

   task automatic test_fast();
      src_data[0 +: 32] = 32'hDEADBEEF;
      drive = 16'h0001;
      #1;
      n_cmp++; if (bus !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fast_bus: got %h want DEADBEEF", bus); end
      n_cmp++; if (bus_valid !== 1'b1) begin n_bad++; $display("FAIL fast_valid: got %b want 1", bus_valid); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fast_stall: got %b want 0", stall); end
      cyc();
      drive = 16'h0000;
      #1;
      n_cmp++; if (bus !== 32'hDEADBEEF) begin n_bad++; $display("FAIL keep_bus: got %h want DEADBEEF", bus); end
      n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL keep_valid: got %b want 0", bus_valid); end
      cyc();
   endtask

   task automatic test_slow();
      src_data[64 +: 32] = 32'h12345678;
      drive = 16'h0004;
      #1;
      for (int c = 0; c < 6; c++) begin
         if (c < 3) begin
            n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL slow_stall c%0d: got %b want 1", c, stall); end
            n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL slow_early c%0d: got %b want 0", c, bus_valid); end
            n_cmp++; if (bus !== 32'hDEADBEEF) begin n_bad++; $display("FAIL slow_keeper c%0d: got %h want DEADBEEF", c, bus); end
         end
         if (c >= 4) begin
            n_cmp++; if (bus_valid !== 1'b1) begin n_bad++; $display("FAIL slow_valid c%0d: got %b want 1", c, bus_valid); end
            n_cmp++; if (bus !== 32'h12345678) begin n_bad++; $display("FAIL slow_bus c%0d: got %h want 12345678", c, bus); end
            n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL slow_nostall c%0d: got %b want 0", c, stall); end
         end
         cyc();
      end
      drive = 16'h0000;
      #1;
      n_cmp++; if (bus !== 32'h12345678) begin n_bad++; $display("FAIL slow_kept: got %h want 12345678", bus); end
      cyc();
   endtask

   task automatic test_contention();
      src_data[128 +: 32] = 32'h0BADF00D;
      drive = 16'h0011;
      #1;
      n_cmp++; if (bus !== 32'h12345678) begin n_bad++; $display("FAIL cont_bus: got %h want 12345678", bus); end
      n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL cont_valid: got %b want 0", bus_valid); end
      n_cmp++; if (contention !== 1'b0) begin n_bad++; $display("FAIL cont_pre: got %b want 0", contention); end
      cyc();
      n_cmp++; if (contention !== 1'b1) begin n_bad++; $display("FAIL cont_flag: got %b want 1", contention); end
      n_cmp++; if (contention_src !== 16'h0011) begin n_bad++; $display("FAIL cont_src: got %h want 0011", contention_src); end
      drive = 16'h0300;
      cyc();
      n_cmp++; if (contention_src !== 16'h0011) begin n_bad++; $display("FAIL cont_first: got %h want 0011", contention_src); end
      n_cmp++; if (contention !== 1'b1) begin n_bad++; $display("FAIL cont_sticky: got %b want 1", contention); end
      drive = 16'h0000;
      cyc();
   endtask

   task automatic test_restart();
      src_data[96 +: 32] = 32'hCAFEF00D;
      drive = 16'h0004;
      cyc();
      drive = 16'h0008;
      #1;
      for (int c = 1; c < 6; c++) begin
         if (c < 5) begin
            n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL rs_early c%0d: got %b want 0", c, bus_valid); end
            n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rs_stall c%0d: got %b want 1", c, stall); end
         end else begin
            n_cmp++; if (bus_valid !== 1'b1) begin n_bad++; $display("FAIL rs_valid c%0d: got %b want 1", c, bus_valid); end
            n_cmp++; if (bus !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rs_bus c%0d: got %h want CAFEF00D", c, bus); end
         end
         cyc();
      end
      drive = 16'h0000;
      cyc();
   endtask

   task automatic test_freeze();
      drive = 16'h0004;
      cyc();
      clock_valid = 1'b0;
      cyc();
      cyc();
      cyc();
      clock_valid = 1'b1;
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL frz_hold: got %b want 1", stall); end
      for (int c = 4; c < 8; c++) begin
         if (c < 7) begin
            n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL frz_early c%0d: got %b want 0", c, bus_valid); end
         end else begin
            n_cmp++; if (bus_valid !== 1'b1) begin n_bad++; $display("FAIL frz_valid c%0d: got %b want 1", c, bus_valid); end
            n_cmp++; if (bus !== 32'h12345678) begin n_bad++; $display("FAIL frz_bus c%0d: got %h want 12345678", c, bus); end
         end
         cyc();
      end
      drive = 16'h0000;
      cyc();
   endtask

   task automatic test_async_reset();
      drive = 16'h0004;
      cyc();
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ar_pre: got %b want 1", stall); end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ar_stall: got %b want 0", stall); end
      n_cmp++; if (bus !== 32'h0) begin n_bad++; $display("FAIL ar_bus: got %h want 0", bus); end
      n_cmp++; if (contention !== 1'b0) begin n_bad++; $display("FAIL ar_cont: got %b want 0", contention); end
      n_cmp++; if (contention_src !== 16'h0) begin n_bad++; $display("FAIL ar_csrc: got %h want 0000", contention_src); end
      n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %b want 0", bus_valid); end
      @(negedge clock);
      drive = 16'h0000;
      reset = 1'b1;
      cyc();
      drive = 16'h0004;
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ar_idle_stall: got %b want 1", stall); end
      n_cmp++; if (bus !== 32'h0) begin n_bad++; $display("FAIL ar_keeper: got %h want 0", bus); end
   endtask

   initial begin
      test_reset();
      test_fast();
      test_slow();
      test_contention();
      test_restart();
      test_freeze();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
